hdmi_pixel_prefetch: RTL and testbench

Single-clock pixel prefetch buffer that sits directly upstream of the HDMI transmit stage in the `Pixl_CLK` domain. It issues burst read requests to the frame-buffer read port and holds the returned 16-bit pixels in a first-word-fall-through FIFO. It pops one pixel per cycle while the transmitter's pixel-active strobe is high. Every rising edge of the transmitter's frame sync flushes the buffer and restarts fetching from the frame base address, sized by the current cut window.

---
 rtl/hdmi_pixel_prefetch.sv | 220 ++++++++++++++++++++++
 tb/tb_hdmi_pixel_prefetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pixel_prefetch.sv
// Pixel prefetch buffer: burst reads from the frame buffer into a FWFT FIFO feeding the HDMI transmitter.
// Optional underflow statistics counter is built when UNDERFLOW_STAT_EN is defined.
module hdmi_pixel_prefetch #(
    parameter int                FIFO_DEPTH = 1024,
    parameter int                BURST_LEN  = 64,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}}
) (
    input  logic                          Pixl_CLK,
    input  logic                          Rst_n,
    input  logic                          I_VGA_Sync,
    input  logic                          I_Pixel_Active,
    output logic [15:0]                   O_Pixel_Data,
    input  logic [11:0]                   Cut_Width,
    input  logic [11:0]                   Cut_High,
    output logic                          O_Rd_Req,
    output logic [ADDR_W-1:0]             O_Rd_Addr,
    output logic [8:0]                    O_Rd_Len,
    input  logic                          I_Rd_Ack,
    input  logic                          I_Rd_Valid,
    input  logic [15:0]                   I_Rd_Data,
    output logic [$clog2(FIFO_DEPTH):0]   O_Fifo_Level,
    output logic                          O_Underflow,
    output logic [15:0]                   O_Underflow_Cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync_q;
    logic [23:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        outst_q, outst_d;
    logic [8:0]        rd_len_q, rd_len_d;
    logic              rd_req_q, rd_req_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              underflow_q, underflow_d;
    logic [15:0]       mem_q [FIFO_DEPTH];

    logic              sync_edge_s;
    logic [8:0]        burst_len_s;
    logic              can_fetch_s;
    logic              beat_s;
    logic              push_s;
    logic              pop_s;
    logic              uf_pop_s;
    logic              flush_done_s;

    assign sync_edge_s  = I_VGA_Sync & ~sync_q;
    assign burst_len_s  = (remaining_q >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remaining_q[8:0];
    assign can_fetch_s  = (remaining_q != 24'd0) && (outst_q == 9'd0)
                          && (level_q <= LW'(FIFO_DEPTH - BURST_LEN));
    // Beats only count against an accepted burst; stray beats after reset are ignored.
    assign beat_s       = I_Rd_Valid && (outst_q != 9'd0);
    assign push_s       = beat_s && (state_q == ST_DATA);
    assign pop_s        = I_Pixel_Active && (level_q != {LW{1'b0}});
    assign uf_pop_s     = I_Pixel_Active && (level_q == {LW{1'b0}});
    assign flush_done_s = (state_q == ST_FLUSH) && !sync_edge_s && (outst_q == 9'd0);

    // State register and all control/datapath registers.
    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            sync_q      <= 1'b0;
            remaining_q <= 24'd0;
            addr_q      <= BASE_ADDR;
            outst_q     <= 9'd0;
            rd_len_q    <= 9'd0;
            rd_req_q    <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= I_VGA_Sync;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            outst_q     <= outst_d;
            rd_len_q    <= rd_len_d;
            rd_req_q    <= rd_req_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state logic; a sync edge preempts every state.
    always_comb begin
        state_d = state_q;
        if (sync_edge_s) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = can_fetch_s ? ST_REQ : ST_IDLE;
                ST_REQ:   state_d = I_Rd_Ack ? ST_DATA : ST_REQ;
                ST_DATA: begin
                    if ((outst_q == 9'd0) || (beat_s && (outst_q == 9'd1))) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_FLUSH: state_d = (outst_q == 9'd0) ? ST_IDLE : ST_FLUSH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: the request strobe is registered from the next state.
    always_comb begin
        rd_req_d = (state_d == ST_REQ);
    end

    // Burst bookkeeping: address, remaining pixels, outstanding beats, latched length.
    always_comb begin
        remaining_d = remaining_q;
        addr_d      = addr_q;
        outst_d     = outst_q;
        rd_len_d    = rd_len_q;
        if ((state_q == ST_REQ) && I_Rd_Ack) begin
            addr_d      = addr_q + ADDR_W'({rd_len_q, 1'b0});
            remaining_d = remaining_q - 24'(rd_len_q);
            outst_d     = rd_len_q;
        end else if (beat_s) begin
            outst_d = outst_q - 9'd1;
        end else begin
            outst_d = outst_q;
        end
        if (sync_edge_s) begin
            remaining_d = {12'd0, Cut_Width} * {12'd0, Cut_High};
        end else begin
            remaining_d = remaining_d;
        end
        if (flush_done_s) begin
            addr_d = BASE_ADDR;
        end else begin
            addr_d = addr_d;
        end
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            rd_len_d = burst_len_s;
        end else begin
            rd_len_d = rd_len_q;
        end
    end

    // FIFO pointers, level and sticky underflow flag.
    always_comb begin
        wr_ptr_d    = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        underflow_d = underflow_q | uf_pop_s;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (flush_done_s) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            level_d     = {LW{1'b0}};
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_d;
        end
    end

    // FIFO storage write port; contents need no reset since level gates the read side.
    always_ff @(posedge Pixl_CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= I_Rd_Data;
        end
    end

`ifdef UNDERFLOW_STAT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    // Saturating underflow counter, cleared with the frame flush.
    always_comb begin
        if (flush_done_s) begin
            uf_cnt_d = 16'd0;
        end else if (uf_pop_s && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end else begin
            uf_cnt_d = uf_cnt_q;
        end
    end

    // Underflow counter register.
    always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            uf_cnt_q <= 16'd0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign O_Underflow_Cnt = uf_cnt_q;
`else
    assign O_Underflow_Cnt = 16'd0;
`endif

    assign O_Pixel_Data = (level_q != {LW{1'b0}}) ? mem_q[rd_ptr_q] : 16'd0;
    assign O_Rd_Req     = rd_req_q;
    assign O_Rd_Addr    = addr_q;
    assign O_Rd_Len     = rd_len_q;
    assign O_Fifo_Level = level_q;
    assign O_Underflow  = underflow_q;

endmodule

// File: tb/tb_hdmi_pixel_prefetch.sv
// Scoreboard bench for hdmi_pixel_prefetch with a small frame-buffer memory model.
module tb_hdmi_pixel_prefetch;

    localparam int          DEPTH = 16;
    localparam int          BL    = 4;
    localparam int          LW    = 5;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync_in, pix_act;
    logic [15:0]   pix_data;
    logic [11:0]   cut_w, cut_h;
    logic          rd_req;
    logic [31:0]   rd_addr;
    logic [8:0]    rd_len;
    logic          rd_ack, rd_valid;
    logic [15:0]   rd_data;
    logic [LW-1:0] level;
    logic          uf;
    logic [15:0]   uf_cnt;

    always #5 clk = ~clk;

    hdmi_pixel_prefetch #(
        .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .ADDR_W(32), .BASE_ADDR(BASE)
    ) dut (
        .Pixl_CLK(clk), .Rst_n(rst_n), .I_VGA_Sync(sync_in), .I_Pixel_Active(pix_act),
        .O_Pixel_Data(pix_data), .Cut_Width(cut_w), .Cut_High(cut_h),
        .O_Rd_Req(rd_req), .O_Rd_Addr(rd_addr), .O_Rd_Len(rd_len), .I_Rd_Ack(rd_ack),
        .I_Rd_Valid(rd_valid), .I_Rd_Data(rd_data), .O_Fifo_Level(level),
        .O_Underflow(uf), .O_Underflow_Cnt(uf_cnt)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [31:0] exp_addr;
    int          exp_rem;
    int          frame_reqs;
    bit          mem_en, pause_mode, mid_pause;
    int          m_len;
    logic [31:0] m_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] pat(input logic [31:0] a);
        return a[16:1] ^ 16'hC3A5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_sync(input int w, input int h);
        cut_w = 12'(w);
        cut_h = 12'(h);
        sync_in = 1'b1;
        exp_q.delete();
        for (int i = 0; i < w * h; i++) exp_q.push_back(pat(BASE + 32'(2 * i)));
        exp_addr   = BASE;
        exp_rem    = w * h;
        frame_reqs = 0;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        int t = 0;
        while (level == '0 && t < 300) begin
            tick();
            t++;
        end
        if (level == '0) begin
            check_eq({tag, "_wait"}, 32'(level != '0), 32'd1);
        end else if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            pix_act = 1'b1;
            check_eq(tag, 32'(pix_data), 32'(exp_q.pop_front()));
            tick();
            pix_act = 1'b0;
        end
    endtask

    task automatic wait_req(input int bound, output bit got);
        int t = 0;
        while (!rd_req && t < bound) begin
            tick();
            t++;
        end
        got = rd_req;
    endtask

    // Frame-buffer model: checks each request against its own address walk, then acks and returns beats.
    initial begin
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 16'd0;
        forever begin
            tick();
            if (mem_en && rst_n && rd_req) begin
                m_addr = rd_addr;
                m_len  = int'(rd_len);
                check_eq("req_addr", m_addr, exp_addr);
                check_eq("req_len", 32'(m_len), 32'((exp_rem < BL) ? exp_rem : BL));
                exp_addr += 32'(2 * m_len);
                exp_rem  -= m_len;
                frame_reqs++;
                repeat ($urandom_range(0, 2)) tick();
                rd_ack = 1'b1;
                tick();
                rd_ack = 1'b0;
                check_eq("req_drop", 32'(rd_req), 32'd0);
                for (int b = 0; b < m_len; b++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    rd_valid = 1'b1;
                    rd_data  = pat(m_addr + 32'(2 * b));
                    tick();
                    rd_valid = 1'b0;
                    if (pause_mode && b == 1) begin
                        mid_pause = 1'b1;
                        settle(8);
                        mid_pause = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        int seen;
        rst_n = 1'b0; sync_in = 1'b0; pix_act = 1'b0; cut_w = 12'd0; cut_h = 12'd0;
        mem_en = 1'b1; pause_mode = 1'b0; mid_pause = 1'b0;
        exp_addr = BASE; exp_rem = 0; frame_reqs = 0;
        settle(2);
        check_eq("rst_pix", 32'(pix_data), 32'd0);
        check_eq("rst_req", 32'(rd_req), 32'd0);
        check_eq("rst_addr", rd_addr, BASE);
        check_eq("rst_len", 32'(rd_len), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_uf", 32'(uf), 32'd0);
        check_eq("rst_ufcnt", 32'(uf_cnt), 32'd0);
        rst_n = 1'b1;
        settle(10);
        check_eq("no_fetch_pre_sync", 32'(frame_reqs), 32'd0);

        // 8x4 frame popped continuously: eight 4-beat bursts, data in order
        drive_sync(8, 4);
        for (int i = 0; i < 32; i++) pop_one("t1_pix");
        settle(20);
        check_eq("t1_reqs", 32'(frame_reqs), 32'd8);
        check_eq("t1_uf", 32'(uf), 32'd0);
        check_eq("t1_level", 32'(level), 32'd0);

        // 10x1 frame, no pops: bursts 4,4,2 and level peaks at 10
        drive_sync(10, 1);
        settle(60);
        check_eq("t2_level", 32'(level), 32'd10);
        check_eq("t2_reqs", 32'(frame_reqs), 32'd3);
        for (int i = 0; i < 10; i++) pop_one("t2_pix");

        // Three pops on an empty FIFO
        settle(4);
        for (int i = 0; i < 3; i++) begin
            pix_act = 1'b1;
            check_eq("t3_pix_zero", 32'(pix_data), 32'd0);
            tick();
        end
        pix_act = 1'b0;
        check_eq("t3_uf", 32'(uf), 32'd1);
`ifdef UNDERFLOW_STAT_EN
        check_eq("t3_ufcnt", 32'(uf_cnt), 32'd3);
`else
        check_eq("t3_ufcnt", 32'(uf_cnt), 32'd0);
`endif
        drive_sync(0, 5);
        settle(3);
        check_eq("t3_uf_clr", 32'(uf), 32'd0);
        check_eq("t3_ufcnt_clr", 32'(uf_cnt), 32'd0);
        settle(20);
        check_eq("t3_zero_cut_reqs", 32'(frame_reqs), 32'd0);
        check_eq("t3_zero_cut_level", 32'(level), 32'd0);

        // Sync edge with 2 of 4 beats still outstanding
        pause_mode = 1'b1;
        drive_sync(8, 1);
        seen = 0;
        while (!mid_pause && seen < 200) begin
            tick();
            seen++;
        end
        pause_mode = 1'b0;
        check_eq("t4_mid_level", 32'(level), 32'd2);
        drive_sync(8, 1);
        wait_req(100, got);
        check_eq("t4_req_after_flush", 32'(got), 32'd1);
        check_eq("t4_level_flushed", 32'(level), 32'd0);
        check_eq("t4_addr_base", rd_addr, BASE);
        for (int i = 0; i < 8; i++) pop_one("t4_pix");

        // Fill to depth with no pops; refetch only once a full burst fits
        settle(10);
        drive_sync(40, 1);
        settle(100);
        check_eq("t5_level_full", 32'(level), 32'(DEPTH));
        check_eq("t5_reqs_full", 32'(frame_reqs), 32'd4);
        pop_one("t5_pix");
        settle(20);
        check_eq("t5_no_req_1free", 32'(frame_reqs), 32'd4);
        for (int i = 0; i < 3; i++) pop_one("t5_pix");
        wait_req(20, got);
        check_eq("t5_req_4free", 32'(got), 32'd1);
        for (int i = 0; i < 36; i++) pop_one("t5_pix");
        settle(10);
        check_eq("t5_reqs_total", 32'(frame_reqs), 32'd10);

        // Reset while a request is pending
        mem_en = 1'b0;
        drive_sync(4, 1);
        wait_req(50, got);
        check_eq("t6_req_up", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_rst", 32'(rd_req), 32'd0);
        check_eq("t6_level_rst", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_req) seen++;
        end
        check_eq("t6_no_req_after_rst", 32'(seen), 32'd0);
        mem_en = 1'b1;
        drive_sync(4, 1);
        for (int i = 0; i < 4; i++) pop_one("t6_pix");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
